// File: rtl/pkg_sfrs_definition.sv
// Shared definitions for the timer SFR bank: tmr_ctrl field layout, register offsets,
// writable/W1C/command bit masks and the bus FSM state encoding.
package pkg_sfrs_definition;

  typedef struct packed {
    logic [16:0] rsvd_31_15;
    logic        ovf_ie;
    logic        match1_ie;
    logic        match0_ie;
    logic        rsvd_11;
    logic        ovf_f;
    logic        match1_f;
    logic        match0_f;
    logic        rsvd_7;
    logic        count_en;
    logic        rd;
    logic        ld;
    logic        rst;
    logic        stop;
    logic        start;
    logic        on;
  } tmr_ctrl_t;

  localparam logic [3:0] TmrCtrlOffset      = 4'h0;
  localparam logic [3:0] TmrValOffset       = 4'h4;
  localparam logic [3:0] TmrMatchVal0Offset = 4'h8;
  localparam logic [3:0] TmrMatchVal1Offset = 4'hC;

  localparam int unsigned BitMatch0F  = 8;
  localparam int unsigned BitMatch1F  = 9;
  localparam int unsigned BitOvfF     = 10;
  localparam int unsigned BitMatch0Ie = 12;
  localparam int unsigned BitMatch1Ie = 13;
  localparam int unsigned BitOvfIe    = 14;

  localparam logic [31:0] CtrlBaseMask = 32'h0000_077F;
  localparam logic [31:0] CtrlIeMask   = 32'h0000_7000;
  localparam logic [31:0] CtrlW1cMask  = 32'h0000_0700;
  localparam logic [31:0] CtrlCmdMask  = 32'h0000_003E;

  typedef enum logic [0:0] {StIdle, StAck} bus_state_e;

endpackage

// File: rtl/sfr_hw_reg.sv
// One SFR with per-bit hardware/software update arbitration, W1C flags and
// command bits where a software 1 beats a same-cycle hardware clear.
module sfr_hw_reg #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] ImplMask = '1,
  parameter logic [Width-1:0] W1cMask  = '0,
  parameter logic [Width-1:0] CmdMask  = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sw_we,
  input  logic [Width-1:0] sw_wdata,
  input  logic [Width-1:0] hw_up,
  input  logic [Width-1:0] hw_val,
  output logic [Width-1:0] value
);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    for (int i = 0; i < Width; i++) begin
      if (W1cMask[i]) begin
        // Hardware set has priority over a software clear.
        if (hw_up[i]) value_d[i] = hw_val[i];
        else if (sw_we && sw_wdata[i]) value_d[i] = 1'b0;
      end else if (CmdMask[i] && sw_we && sw_wdata[i]) begin
        value_d[i] = 1'b1;
      end else if (hw_up[i]) begin
        value_d[i] = hw_val[i];
      end else if (sw_we) begin
        value_d[i] = sw_wdata[i];
      end
    end
    value_d = value_d & ImplMask;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) value_q <= '0;
    else            value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/timer_sfr_bank.sv
// Timer SFR bank: four registers behind a req/ack bus with an IDLE/ACK handshake.
// Optional macro TMR_SFR_IRQ_EN enables the interrupt-enable bits and the irq output.
module timer_sfr_bank
  import pkg_sfrs_definition::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_ack,
  output logic                  bus_err,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [DATA_WIDTH-1:0] tmr_ctrl,
  output logic [DATA_WIDTH-1:0] tmr_val,
  output logic [DATA_WIDTH-1:0] tmr_match_val0,
  output logic [DATA_WIDTH-1:0] tmr_match_val1,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_ctrl,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_val,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_match_val0,
  input  logic [DATA_WIDTH-1:0] hw_up_tmr_match_val1,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_ctrl,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_val,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_match_val0,
  input  logic [DATA_WIDTH-1:0] hw_val_tmr_match_val1,
  output logic                  irq
);

`ifdef TMR_SFR_IRQ_EN
  localparam logic [31:0] CtrlImplMask = CtrlBaseMask | CtrlIeMask;
`else
  localparam logic [31:0] CtrlImplMask = CtrlBaseMask;
`endif

  bus_state_e            state_q;
  logic                  addr_bad, sw_wr;
  logic [3:0]            sw_we;
  logic [DATA_WIDTH-1:0] rdata_mux, ctrl_hw_val;
  tmr_ctrl_t             ctrl_hw_fields;

  assign addr_bad = (bus_addr[1:0] != 2'b00) || (bus_addr > ADDR_WIDTH'(TmrMatchVal1Offset));
  assign sw_wr    = (state_q == StIdle) && bus_req && bus_we && !addr_bad;

  always_comb begin
    sw_we     = '0;
    rdata_mux = '0;
    case (bus_addr[3:0])
      TmrCtrlOffset:      begin sw_we[0] = sw_wr; rdata_mux = tmr_ctrl;       end
      TmrValOffset:       begin sw_we[1] = sw_wr; rdata_mux = tmr_val;        end
      TmrMatchVal0Offset: begin sw_we[2] = sw_wr; rdata_mux = tmr_match_val0; end
      TmrMatchVal1Offset: begin sw_we[3] = sw_wr; rdata_mux = tmr_match_val1; end
      default: ;
    endcase
  end

  // An overflow strobe always sets the flag, whatever value accompanies it.
  always_comb begin
    ctrl_hw_fields       = tmr_ctrl_t'(hw_val_tmr_ctrl[31:0]);
    ctrl_hw_fields.ovf_f = 1'b1;
  end
  assign ctrl_hw_val = DATA_WIDTH'(ctrl_hw_fields);

  sfr_hw_reg #(
    .Width    (DATA_WIDTH),
    .ImplMask (DATA_WIDTH'(CtrlImplMask)),
    .W1cMask  (DATA_WIDTH'(CtrlW1cMask)),
    .CmdMask  (DATA_WIDTH'(CtrlCmdMask))
  ) u_tmr_ctrl (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sw_we     (sw_we[0]),
    .sw_wdata  (bus_wdata),
    .hw_up     (hw_up_tmr_ctrl),
    .hw_val    (ctrl_hw_val),
    .value     (tmr_ctrl)
  );

  sfr_hw_reg #(.Width(DATA_WIDTH)) u_tmr_val (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sw_we     (sw_we[1]),
    .sw_wdata  (bus_wdata),
    .hw_up     (hw_up_tmr_val),
    .hw_val    (hw_val_tmr_val),
    .value     (tmr_val)
  );

  sfr_hw_reg #(.Width(DATA_WIDTH)) u_tmr_match_val0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sw_we     (sw_we[2]),
    .sw_wdata  (bus_wdata),
    .hw_up     (hw_up_tmr_match_val0),
    .hw_val    (hw_val_tmr_match_val0),
    .value     (tmr_match_val0)
  );

  sfr_hw_reg #(.Width(DATA_WIDTH)) u_tmr_match_val1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sw_we     (sw_we[3]),
    .sw_wdata  (bus_wdata),
    .hw_up     (hw_up_tmr_match_val1),
    .hw_val    (hw_val_tmr_match_val1),
    .value     (tmr_match_val1)
  );

  // Read data samples the registers before any update on the same edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus_req) begin
            state_q   <= StAck;
            bus_ack   <= 1'b1;
            bus_err   <= addr_bad;
            bus_rdata <= (bus_we || addr_bad) ? '0 : rdata_mux;
          end
        end
        default: begin
          state_q   <= StIdle;
          bus_ack   <= 1'b0;
          bus_err   <= 1'b0;
          bus_rdata <= '0;
        end
      endcase
    end
  end

`ifdef TMR_SFR_IRQ_EN
  logic irq_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) irq_q <= 1'b0;
    else irq_q <= (tmr_ctrl[BitMatch0F] & tmr_ctrl[BitMatch0Ie]) |
                  (tmr_ctrl[BitMatch1F] & tmr_ctrl[BitMatch1Ie]) |
                  (tmr_ctrl[BitOvfF]    & tmr_ctrl[BitOvfIe]);
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_timer_sfr_bank.sv
// Directed bench for timer_sfr_bank; expectations follow the TMR_SFR_IRQ_EN build setting.
module tb_timer_sfr_bank;

`ifdef TMR_SFR_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif
  localparam logic [31:0] CtrlRw = IrqEn ? 32'h0000_707F : 32'h0000_007F;
  localparam logic [31:0] Ie0    = IrqEn ? 32'h0000_1000 : 32'h0000_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        bus_req, bus_we, bus_ack, bus_err, irq;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [31:0] tmr_ctrl, tmr_val, tmr_match_val0, tmr_match_val1;
  logic [31:0] hw_up_tmr_ctrl, hw_up_tmr_val, hw_up_tmr_match_val0, hw_up_tmr_match_val1;
  logic [31:0] hw_val_tmr_ctrl, hw_val_tmr_val, hw_val_tmr_match_val0, hw_val_tmr_match_val1;

  int          n_vec = 0;
  int          n_miss = 0;
  logic        got_ack, got_err, got_irq, next_ack, ack_seen;
  logic [31:0] got_rdata;

  timer_sfr_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .sys_clk               (sys_clk),
    .sys_rst_n             (sys_rst_n),
    .bus_req               (bus_req),
    .bus_we                (bus_we),
    .bus_addr              (bus_addr),
    .bus_wdata             (bus_wdata),
    .bus_ack               (bus_ack),
    .bus_err               (bus_err),
    .bus_rdata             (bus_rdata),
    .tmr_ctrl              (tmr_ctrl),
    .tmr_val               (tmr_val),
    .tmr_match_val0        (tmr_match_val0),
    .tmr_match_val1        (tmr_match_val1),
    .hw_up_tmr_ctrl        (hw_up_tmr_ctrl),
    .hw_up_tmr_val         (hw_up_tmr_val),
    .hw_up_tmr_match_val0  (hw_up_tmr_match_val0),
    .hw_up_tmr_match_val1  (hw_up_tmr_match_val1),
    .hw_val_tmr_ctrl       (hw_val_tmr_ctrl),
    .hw_val_tmr_val        (hw_val_tmr_val),
    .hw_val_tmr_match_val0 (hw_val_tmr_match_val0),
    .hw_val_tmr_match_val1 (hw_val_tmr_match_val1),
    .irq                   (irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_hw();
    hw_up_tmr_ctrl = '0;        hw_val_tmr_ctrl = '0;
    hw_up_tmr_val = '0;         hw_val_tmr_val = '0;
    hw_up_tmr_match_val0 = '0;  hw_val_tmr_match_val0 = '0;
    hw_up_tmr_match_val1 = '0;  hw_val_tmr_match_val1 = '0;
  endtask

  task automatic set_hw(input int sel, input logic [31:0] up, input logic [31:0] val);
    case (sel)
      0: begin hw_up_tmr_ctrl = up;       hw_val_tmr_ctrl = val;       end
      1: begin hw_up_tmr_val = up;        hw_val_tmr_val = val;        end
      2: begin hw_up_tmr_match_val0 = up; hw_val_tmr_match_val0 = val; end
      3: begin hw_up_tmr_match_val1 = up; hw_val_tmr_match_val1 = val; end
      default: ;
    endcase
  endtask

  // Full transaction: drive at negedge, sample 1 time unit after the access edge,
  // then let the ACK cycle retire so the next call starts from IDLE.
  task automatic bus_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input int hw_sel, input logic [31:0] up, input logic [31:0] val);
    @(negedge sys_clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    set_hw(hw_sel, up, val);
    @(posedge sys_clk); #1;
    got_ack = bus_ack; got_err = bus_err; got_rdata = bus_rdata; got_irq = irq;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    clr_hw();
    @(posedge sys_clk); #1;
    next_ack = bus_ack;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    bus_xfer(1'b1, addr, data, -1, '0, '0);
  endtask

  task automatic rd(input logic [7:0] addr);
    bus_xfer(1'b0, addr, '0, -1, '0, '0);
  endtask

  task automatic hw_pulse(input int sel, input logic [31:0] up, input logic [31:0] val);
    @(negedge sys_clk);
    set_hw(sel, up, val);
    @(posedge sys_clk); #1;
    clr_hw();
  endtask

  initial begin
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    clr_hw();
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_ctrl", tmr_ctrl, 32'h0);
    check("rst_val", tmr_val, 32'h0);
    check("rst_m0", tmr_match_val0, 32'h0);
    check("rst_m1", tmr_match_val1, 32'h0);
    check("rst_ack", bus_ack, 1'b0);
    check("rst_err", bus_err, 1'b0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_irq", irq, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Start command set by software, cleared by hardware
    wr(8'h0, 32'h0000_0002);
    check("start_ack", got_ack, 1'b1);
    check("start_err", got_err, 1'b0);
    check("start_wr_rdata", got_rdata, 32'h0);
    check("start_ctrl", tmr_ctrl, 32'h0000_0002);
    check("ack_one_cycle", next_ack, 1'b0);
    hw_pulse(0, 32'h0000_0002, 32'h0);
    check("start_hw_clr", tmr_ctrl, 32'h0);

    // Writable mask and readback
    wr(8'h0, 32'hFFFF_FFFF);
    check("ctrl_mask", tmr_ctrl, CtrlRw);
    rd(8'h0);
    check("ctrl_rd", got_rdata, CtrlRw);
    wr(8'h0, 32'h0);
    check("ctrl_zero", tmr_ctrl, 32'h0);

    // Match0 flag to irq and W1C clear
    wr(8'h0, 32'h0000_1000);
    check("ie0_wr", tmr_ctrl, Ie0);
    hw_pulse(0, 32'h0000_0100, 32'h0000_0100);
    check("m0f_set", tmr_ctrl, Ie0 | 32'h0000_0100);
    check("irq_lat0", irq, 1'b0);
    @(posedge sys_clk); #1;
    check("irq_lat1", irq, IrqEn);
    wr(8'h0, 32'h0000_0100);
    check("m0f_clr", tmr_ctrl, 32'h0);
    check("irq_at_clr", got_irq, IrqEn);
    check("irq_off", irq, 1'b0);

    // Overflow flag: value-independent set, hw set beats sw clear
    hw_pulse(0, 32'h0000_0400, 32'h0);
    check("ovf_set", tmr_ctrl, 32'h0000_0400);
    bus_xfer(1'b1, 8'h0, 32'h0000_0400, 0, 32'h0000_0400, 32'h0);
    check("ovf_hw_wins", tmr_ctrl, 32'h0000_0400);
    wr(8'h0, 32'h0000_0400);
    check("ovf_w1c", tmr_ctrl, 32'h0);
    hw_pulse(0, 32'h0000_0200, 32'h0000_0200);
    wr(8'h0, 32'h0);
    check("m1f_w0_hold", tmr_ctrl, 32'h0000_0200);
    wr(8'h0, 32'h0000_0200);
    check("m1f_w1c", tmr_ctrl, 32'h0);

    // Command bits: sw 1 beats hw clear; plain 'on' bit: hw wins
    bus_xfer(1'b1, 8'h0, 32'h0000_003F, 0, 32'h0000_003F, 32'h0);
    check("cmd_prio", tmr_ctrl, 32'h0000_003E);
    wr(8'h0, 32'h0);
    check("cmd_clr", tmr_ctrl, 32'h0);

    // Bad addresses
    wr(8'h4, 32'h0000_00AA);
    check("val_wr", tmr_val, 32'h0000_00AA);
    wr(8'h6, 32'hFFFF_FFFF);
    check("bad_wr_err", got_err, 1'b1);
    check("bad_wr_val", tmr_val, 32'h0000_00AA);
    rd(8'h6);
    check("bad6_ack", got_ack, 1'b1);
    check("bad6_err", got_err, 1'b1);
    check("bad6_rdata", got_rdata, 32'h0);
    rd(8'h10);
    check("bad10_ack", got_ack, 1'b1);
    check("bad10_err", got_err, 1'b1);
    check("bad10_rdata", got_rdata, 32'h0);
    check("bad10_ctrl", tmr_ctrl, 32'h0);
    rd(8'h4);
    check("val_rd_err", got_err, 1'b0);
    check("val_rd", got_rdata, 32'h0000_00AA);

    // Hardware load of the counter value
    hw_pulse(1, 32'hFFFF_FFFF, 32'h1234_5678);
    check("val_hw", tmr_val, 32'h1234_5678);
    rd(8'h4);
    check("val_hw_rd", got_rdata, 32'h1234_5678);

    // Match registers
    wr(8'h8, 32'hA5A5_0001);
    wr(8'hC, 32'hDEAD_BEEF);
    check("m0_out", tmr_match_val0, 32'hA5A5_0001);
    check("m1_out", tmr_match_val1, 32'hDEAD_BEEF);
    rd(8'h8);
    check("m0_rd", got_rdata, 32'hA5A5_0001);
    rd(8'hC);
    check("m1_rd", got_rdata, 32'hDEAD_BEEF);

    // Per-bit hw/sw arbitration on the value register
    bus_xfer(1'b1, 8'h4, 32'hFFFF_FFFF, 1, 32'h0000_FFFF, 32'h0);
    check("val_perbit", tmr_val, 32'hFFFF_0000);

    // Reset in the middle of an ACK cycle
    wr(8'h0, 32'h0000_0041);
    check("ctrl_pre_rst", tmr_ctrl, 32'h0000_0041);
    @(negedge sys_clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 8'h4;
    @(posedge sys_clk); #1;
    check("mid_ack", bus_ack, 1'b1);
    check("mid_rdata", bus_rdata, 32'hFFFF_0000);
    bus_req = 1'b0; bus_addr = '0;
    sys_rst_n = 1'b0;
    #1;
    check("abort_ack", bus_ack, 1'b0);
    check("abort_rdata", bus_rdata, 32'h0);
    check("abort_ctrl", tmr_ctrl, 32'h0);
    check("abort_val", tmr_val, 32'h0);
    check("abort_m0", tmr_match_val0, 32'h0);
    check("abort_m1", tmr_match_val1, 32'h0);
    check("abort_irq", irq, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ack_seen = 1'b0;
    repeat (4) begin
      @(posedge sys_clk); #1;
      ack_seen = ack_seen | bus_ack;
    end
    check("no_ack_after_rst", ack_seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/timer_sfr_bank.md
TIMER_SFR_BANK -- requirements
Module: timer_sfr_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and bus data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, byte address width of the bus port.
REQ-003 SHALL have port sys_clk, input, 1, the single clock; all flops on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports bus_req/bus_we, input, 1 each; bus_addr, input, ADDR_WIDTH; bus_wdata, input, DATA_WIDTH: software access request.
REQ-006 SHALL have ports bus_ack/bus_err, output, 1 each; bus_rdata, output, DATA_WIDTH: access completion.
REQ-007 SHALL have outputs tmr_ctrl, tmr_val, tmr_match_val0, tmr_match_val1, DATA_WIDTH each: register contents driven to the timer.
REQ-008 SHALL have inputs hw_up_tmr_ctrl/val/match_val0/match_val1 and hw_val_tmr_ctrl/val/match_val0/match_val1, DATA_WIDTH each: per-bit hardware update strobe and value from the timer.
REQ-009 SHALL have output irq, 1, timer interrupt request.

Function
REQ-010 SHALL map registers at byte offsets 0x0 tmr_ctrl, 0x4 tmr_val, 0x8 tmr_match_val0, 0xC tmr_match_val1.
REQ-011 SHALL use tmr_ctrl layout: on[0], start[1], stop[2], rst[3], ld[4], rd[5], count_en[6], match0_f[8], match1_f[9], ovf_f[10], match0_ie[12], match1_ie[13], ovf_ie[14]; other bits reserved, read 0, writes ignored.
REQ-012 SHALL implement the bus FSM with states IDLE and ACK: IDLE with bus_req=1 performs the access at that edge and enters ACK; ACK asserts bus_ack for exactly one cycle, then returns to IDLE regardless of bus_req.
REQ-013 SHALL register bus_rdata on the access edge (read data = register value before any same-edge update); bus_rdata is 0 on writes and in IDLE.
REQ-014 SHALL, for an address outside 0x0-0xC or not 4-byte aligned, perform no write, return rdata 0 and assert bus_err together with bus_ack.
REQ-015 SHALL update each bit per cycle: if hw_up bit=1 take hw_val bit, else if SW write to that bit take wdata bit, else hold; command bits start/stop/rst/ld/rd are the exception: SW write of 1 wins over a same-cycle hardware clear.
REQ-016 SHALL treat match0_f/match1_f/ovf_f as W1C from software; a same-cycle hardware set wins over software clear; writing 0 leaves the flag unchanged.
REQ-017 SHALL set ovf_f from hw_up_tmr_ctrl.ovf_f with value 1 irrespective of hw_val_tmr_ctrl.ovf_f.
REQ-018 SHALL drive irq registered: irq(n+1) = OR of (flag & ie) at cycle n; one-cycle latency from flag set; deasserts one cycle after last enabled flag clears.
REQ-019 SHALL drive tmr_* outputs directly from the register flops (no added latency).
REQ-020 SHALL let tmr_match_val0/1 be software-only (hardware strobes on those registers honoured per REQ-015 but expected 0).

Reset
REQ-021 SHALL on sys_rst_n=0 clear all registers, FSM to IDLE, bus_ack=0, bus_err=0, bus_rdata=0, irq=0, asynchronously.
REQ-022 SHALL abort an access in flight when reset asserts mid-ACK; no ack issued after reset release.

Configuration
REQ-023 SHALL use macro TMR_SFR_IRQ_EN: defined -> ie bits writable and irq per REQ-018; undefined -> ie bits read 0, writes ignored, irq tied 0, flags still operate.

Structure
REQ-024 SHALL place tmr_ctrl_t field layout, register offset constants and the FSM state enum in pkg_sfrs_definition.
REQ-025 SHALL instantiate sub-module sfr_hw_reg (one DATA_WIDTH register with SW write-enable/data, hw_up/hw_val, per-bit W1C mask) once per register.

Verification
REQ-026 Write 0x0000_0002 to 0x0 -> bus_ack 1 cycle after req, tmr_ctrl[1]=1; next cycle hw_up bit1=1, hw_val 0 -> tmr_ctrl[1]=0.
REQ-027 hw_up/hw_val match0_f=1 with match0_ie=1 -> match0_f=1, irq=1 one cycle later; write 0x100 to 0x0 -> flag and irq clear.
REQ-028 Same cycle: SW writes 0x400 (clear ovf_f) and hw sets ovf_f -> ovf_f stays 1.
REQ-029 Read 0x6 and 0x10 -> bus_ack and bus_err 1, rdata 0, no register change.
REQ-030 hw_up_tmr_val all-ones, hw_val 0x1234_5678 then read 0x4 -> rdata 0x1234_5678.
REQ-031 Reset asserted during ACK -> bus_ack 0 immediately, all registers 0; build without TMR_SFR_IRQ_EN -> irq stays 0 in REQ-027.
